// File: rtl/ecc_apb_pkg.sv
// ============================================================================
// Module : ecc_apb_pkg
// Brief  : Shared types and constants for the ECC APB command master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ecc_apb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ACCESS    = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // ECC register map, relative to the block base address
  localparam logic [7:0] OFF_CTRL           = 8'h00;
  localparam logic [7:0] OFF_DATA_IN        = 8'h04;
  localparam logic [7:0] OFF_CODEWORD_WIDTH = 8'h08;
  localparam logic [7:0] OFF_NOISE          = 8'h0C;

  // Write sequence slots; CTRL goes last because writing it starts the operation
  localparam logic [1:0] WR_DATA_IN        = 2'd0;
  localparam logic [1:0] WR_CODEWORD_WIDTH = 2'd1;
  localparam logic [1:0] WR_NOISE          = 2'd2;
  localparam logic [1:0] WR_CTRL           = 2'd3;

  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0] STATUS_ILLEGAL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ecc_apb_cmd_master.sv
// ============================================================================
// Module : ecc_apb_cmd_master
// Brief  : APB master that programs the ECC block for one job at a time and
//          returns its result (or a timeout/illegal-mode status).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecc_apb_cmd_master
  import ecc_apb_pkg::*;
#(
  parameter int                         AMBA_ADDR_WIDTH = 32,
  parameter int                         AMBA_WORD       = 32,
  parameter int                         DATA_WIDTH      = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_mode,
  input  logic [1:0]                 req_width,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [DATA_WIDTH-1:0]      req_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_errors,
  output logic [1:0]                 rsp_status
);

  localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [1:0]            r_idx;
  logic [1:0]            r_mode;
  logic [1:0]            r_width;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_noise;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_num_errors;
  logic [1:0]            r_rsp_status;
  logic [7:0]            w_offset;
  logic [AMBA_WORD-1:0]  w_field;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Offset/data mux selected by the write index
  always_comb begin
    w_offset = OFF_DATA_IN;
    w_field  = '0;
    case (r_idx)
      WR_DATA_IN: begin
        w_offset = OFF_DATA_IN;
        w_field  = AMBA_WORD'(r_data);
      end
      WR_CODEWORD_WIDTH: begin
        w_offset = OFF_CODEWORD_WIDTH;
        w_field  = AMBA_WORD'(r_width);
      end
      WR_NOISE: begin
        w_offset = OFF_NOISE;
        w_field  = AMBA_WORD'(r_noise);
      end
      default: begin
        w_offset = OFF_CTRL;
        w_field  = AMBA_WORD'(r_mode);
      end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    psel         = 1'b0;
    penable      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_state = (req_mode == MODE_ILLEGAL) ? RESP : SETUP;
        end
      end
      SETUP: begin
        psel         = 1'b1;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        psel         = 1'b1;
        penable      = 1'b1;
        w_next_state = (r_idx == WR_CTRL) ? WAIT_DONE : SETUP;
      end
      WAIT_DONE: begin
        if (operation_done || (r_cnt == C_CNT_LAST)) w_next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    pwrite = psel;
    paddr  = psel ? (BASE_ADDR + AMBA_ADDR_WIDTH'(w_offset)) : '0;
    pwdata = psel ? w_field : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx            <= '0;
      r_mode           <= '0;
      r_width          <= '0;
      r_data           <= '0;
      r_noise          <= '0;
      r_cnt            <= '0;
      r_rsp_data       <= '0;
      r_rsp_num_errors <= '0;
      r_rsp_status     <= STATUS_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_mode  <= req_mode;
            r_width <= req_width;
            r_data  <= req_data;
            r_noise <= req_noise;
            r_idx   <= WR_DATA_IN;
            if (req_mode == MODE_ILLEGAL) begin
              r_rsp_data       <= '0;
              r_rsp_num_errors <= '0;
              r_rsp_status     <= STATUS_ILLEGAL;
            end
          end
        end
        ACCESS: begin
          r_idx <= r_idx + 2'd1;
          r_cnt <= '0;
        end
        WAIT_DONE: begin
          // A done pulse on the last allowed cycle still counts as success
          if (operation_done) begin
            r_rsp_data       <= data_out;
            r_rsp_num_errors <= num_of_errors;
            r_rsp_status     <= STATUS_OK;
          end else if (r_cnt == C_CNT_LAST) begin
            r_rsp_data       <= '0;
            r_rsp_num_errors <= '0;
            r_rsp_status     <= STATUS_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated with rst so req_ready stays low while reset is held
  assign req_ready      = (r_state == IDLE) && rst;
  assign rsp_valid      = (r_state == RESP);
  assign rsp_data       = r_rsp_data;
  assign rsp_num_errors = r_rsp_num_errors;
  assign rsp_status     = r_rsp_status;

endmodule

`default_nettype wire

// File: tb/tb_ecc_apb_cmd_master.sv
// ============================================================================
// Module : tb_ecc_apb_cmd_master
// Brief  : Scoreboard bench for ecc_apb_cmd_master with a behavioural ECC model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ecc_apb_cmd_master;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] BASE    = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } apb_exp_t;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] data;
    logic [1:0]  nerr;
    int          lat;
  } rsp_exp_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_mode;
  logic [1:0]    req_width;
  logic [DW-1:0] req_data;
  logic [DW-1:0] req_noise;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic          operation_done;
  logic [DW-1:0] data_out;
  logic [1:0]    num_of_errors;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_num_errors;
  logic [1:0]    rsp_status;

  int n_checks = 0;
  int n_errors = 0;
  int model_delay;
  bit stray_done;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];

  ecc_apb_cmd_master #(
    .AMBA_ADDR_WIDTH (AW),
    .AMBA_WORD       (32),
    .DATA_WIDTH      (DW),
    .BASE_ADDR       (BASE),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mode       (req_mode),
    .req_width      (req_width),
    .req_data       (req_data),
    .req_noise      (req_noise),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .operation_done (operation_done),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_num_errors (rsp_num_errors),
    .rsp_status     (rsp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] err_count(input logic [31:0] noise);
    int ones;
    ones = $countones(noise);
    return (ones > 2) ? 2'd2 : 2'(ones);
  endfunction

  // Behavioural ECC: result = data ^ noise, errors = popcount(noise) capped at 2
  initial begin : ecc_model
    int          cnt;
    logic [31:0] m_data;
    logic [31:0] m_noise;
    cnt            = -1;
    m_data         = '0;
    m_noise        = '0;
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = '0;
    forever begin
      @(negedge clk);
      operation_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          operation_done = 1'b1;
          data_out       = m_data ^ m_noise;
          num_of_errors  = err_count(m_noise);
          cnt            = -1;
        end
      end
      if (psel && penable) begin
        if (paddr == BASE + 32'h4) begin
          m_data = pwdata;
          if (stray_done) begin
            operation_done = 1'b1;
            data_out       = 32'hDEAD_BEEF;
            num_of_errors  = 2'd3;
          end
        end
        if (paddr == BASE + 32'hC) m_noise = pwdata;
        if (paddr == BASE && model_delay > 0) cnt = model_delay;
      end
    end
  end

  initial begin : apb_monitor
    apb_exp_t e;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        if (apb_q.size() == 0) begin
          check_eq("apb_unexpected", 64'(psel), 64'd0);
        end else begin
          e = apb_q.pop_front();
          check_eq("apb_addr", 64'(paddr), 64'(e.addr));
          check_eq("apb_wdata", 64'(pwdata), 64'(e.data));
          check_eq("apb_pwrite", 64'(pwrite), 64'd1);
        end
      end
    end
  end

  task automatic push_writes(input logic [1:0] mode, input logic [1:0] width,
                             input logic [31:0] data, input logic [31:0] noise, input int n);
    apb_exp_t w[4];
    w[0] = '{BASE + 32'h4, data};
    w[1] = '{BASE + 32'h8, 32'(width)};
    w[2] = '{BASE + 32'hC, noise};
    w[3] = '{BASE,         32'(mode)};
    for (int i = 0; i < n; i++) apb_q.push_back(w[i]);
  endtask

  task automatic run_job(input logic [1:0] mode, input logic [1:0] width,
                         input logic [31:0] data, input logic [31:0] noise,
                         input int delay, input int hold, input bit stray);
    rsp_exp_t e;
    int       lat;
    model_delay = delay;
    stray_done  = stray;
    if (mode == 2'd3) begin
      e = '{2'd2, 32'd0, 2'd0, 1};
    end else begin
      push_writes(mode, width, data, noise, 4);
      if (delay < 1 || delay > TIMEOUT) e = '{2'd1, 32'd0, 2'd0, 9 + TIMEOUT};
      else                              e = '{2'd0, data ^ noise, err_count(noise), 9 + delay};
    end
    rsp_q.push_back(e);

    req_mode  = mode;
    req_width = width;
    req_data  = data;
    req_noise = noise;
    req_valid = 1'b1;
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom;
    req_noise = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = rsp_q.pop_front();
    check_eq("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    check_eq("rsp_status", 64'(rsp_status), 64'(e.status));
    check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
    check_eq("rsp_num_errors", 64'(rsp_num_errors), 64'(e.nerr));
    check_eq("rsp_latency", 64'(lat), 64'(e.lat));
    check_eq("req_ready_busy", 64'(req_ready), 64'd0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_eq("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_rsp_status", 64'(rsp_status), 64'(e.status));
      check_eq("hold_rsp_data", 64'(rsp_data), 64'(e.data));
      check_eq("hold_rsp_nerr", 64'(rsp_num_errors), 64'(e.nerr));
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check_eq("req_ready_back", 64'(req_ready), 64'd1);
    check_eq("apb_q_drained", 64'(apb_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bound;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_mode    = '0;
    req_width   = '0;
    req_data    = '0;
    req_noise   = '0;
    rsp_ready   = 1'b0;
    model_delay = -1;
    stray_done  = 1'b0;

    @(negedge clk);
    check_eq("reset_psel", 64'(psel), 64'd0);
    check_eq("reset_req_ready", 64'(req_ready), 64'd0);
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_reset_req_ready", 64'(req_ready), 64'd1);
    check_eq("post_reset_rsp_status", 64'(rsp_status), 64'd0);
    check_eq("post_reset_rsp_data", 64'(rsp_data), 64'd0);

    run_job(2'd0, 2'd0, 32'h0000_00A5, 32'h0,         5,  0, 1'b0); // encode
    run_job(2'd2, 2'd2, 32'h1234_5678, 32'h0000_0001, 1,  0, 1'b0); // one injected error
    run_job(2'd1, 2'd1, 32'hCAFE_0F00, 32'h0000_0300, 3,  0, 1'b1); // stray done during writes
    run_job(2'd3, 2'd1, 32'h5555_AAAA, 32'hFFFF_FFFF, 2,  0, 1'b0); // illegal mode
    run_job(2'd0, 2'd3, 32'h0BAD_F00D, 32'h0,         -1, 0, 1'b0); // timeout
    run_job(2'd2, 2'd0, 32'h8000_0001, 32'h0000_0007, 16, 0, 1'b0); // done on expiry cycle
    run_job(2'd1, 2'd2, 32'h7777_7777, 32'h0,         17, 0, 1'b0); // done just too late
    run_job(2'd0, 2'd1, 32'h0F0F_1234, 32'h0000_0010, 2,  10, 1'b0); // backpressure
    run_job(2'd2, 2'd3, 32'hA5A5_5A5A, 32'h8000_0000, 1,  0, 1'b0); // accepted next cycle

    // Reset asserted in the middle of the NOISE access
    model_delay = -1;
    stray_done  = 1'b0;
    push_writes(2'd1, 2'd1, 32'h0F0F_0F0F, 32'h3, 3);
    req_mode  = 2'd1;
    req_width = 2'd1;
    req_data  = 32'h0F0F_0F0F;
    req_noise = 32'h3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    bound = 0;
    while (!(psel && penable && paddr == BASE + 32'hC) && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    check_eq("reach_noise_access", 64'(psel && penable), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("midreset_psel", 64'(psel), 64'd0);
    check_eq("midreset_penable", 64'(penable), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midreset_req_ready", 64'(req_ready), 64'd1);
    check_eq("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("midreset_apb_q", 64'(apb_q.size()), 64'd0);
    @(negedge clk);
    run_job(2'd2, 2'd2, 32'h1357_9BDF, 32'h0000_0001, 4, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
